// File: rtl/rename_alloc_ctrl.sv
// rename_alloc_ctrl: free-list bitmap allocator with branch checkpoints and mispredict recovery.
// Define RENAME_DUAL_ALLOC_EN to grant two pregs per cycle; default grants slot 0 only.
module rename_alloc_ctrl #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH = 32,
    parameter int MAX_PREDICT_DEPTH = 4,
    localparam int PW = $clog2(NUM_PREGS),
    localparam int TW = $clog2(MAX_PREDICT_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    alloc_req,
    output logic          alloc_ready,
    output logic [PW-1:0] alloc_preg0,
    output logic [PW-1:0] alloc_preg1,
    input  logic [1:0]    free_valid,
    input  logic [PW-1:0] free_preg0,
    input  logic [PW-1:0] free_preg1,
    input  logic          ckpt_valid,
    input  logic [TW-1:0] ckpt_tag,
    input  logic          shoot_valid,
    input  logic [TW-1:0] shoot_tag,
    input  logic          resolve_valid,
    input  logic [TW-1:0] resolve_tag,
    output logic [PW:0]   num_free,
    output logic          recovering,
    output logic          err
);
    typedef enum logic {RUN, RECOVER} state_t;
    state_t state;
    logic [NUM_PREGS-1:0] bitmap, gmask, fmask, nxt, shoot_map;
    logic [NUM_PREGS-1:0] ckpt [MAX_PREDICT_DEPTH];
    logic [MAX_PREDICT_DEPTH-1:0] ckpt_v, ckpt_sel, res_sel, kill;
    logic [1:0] req;
    logic [PW-1:0] first;
    logic free_err, ckpt_ok, shoot_ok;
`ifdef RENAME_DUAL_ALLOC_EN
    logic [PW-1:0] second;
`endif

    // Scanning downward leaves the lowest free index in first and the next one in second.
    always_comb begin
        num_free = '0;
        first = '0;
`ifdef RENAME_DUAL_ALLOC_EN
        second = '0;
`endif
        for (int i = NUM_PREGS - 1; i >= 0; i--)
            if (bitmap[i]) begin
                num_free = num_free + (PW+1)'(1);
`ifdef RENAME_DUAL_ALLOC_EN
                second = first;
`endif
                first = PW'(i);
            end
    end

`ifdef RENAME_DUAL_ALLOC_EN
    assign req = alloc_req;
    assign alloc_ready = state == RUN && !shoot_valid && num_free >= (PW+1)'(req[0]) + (PW+1)'(req[1]);
    assign alloc_preg1 = req == 2'b10 ? first : second;
`else
    logic unused;
    assign unused = alloc_req[1];
    assign req = {1'b0, alloc_req[0]};
    assign alloc_ready = state == RUN && !shoot_valid && num_free != '0;
    assign alloc_preg1 = '0;
`endif
    assign alloc_preg0 = first;
    assign recovering = state == RECOVER;

    always_comb begin
        gmask = '0;
        if (alloc_ready && req[0]) gmask[first] = 1'b1;
        if (alloc_ready && req[1]) gmask[alloc_preg1] = 1'b1;
        fmask = '0;
        free_err = 1'b0;
        if (free_valid[0]) begin
            free_err = bitmap[free_preg0];
            fmask[free_preg0] = 1'b1;
        end
        if (free_valid[1]) begin
            free_err = free_err | bitmap[free_preg1] | fmask[free_preg1];
            fmask[free_preg1] = 1'b1;
        end
        shoot_map = '0;
        ckpt_ok = 1'b0;
        shoot_ok = 1'b0;
        ckpt_sel = '0;
        res_sel = '0;
        kill = '0;
        for (int k = 0; k < MAX_PREDICT_DEPTH; k++) begin
            ckpt_sel[k] = ckpt_tag == TW'(k + 1);
            res_sel[k] = resolve_valid && resolve_tag == TW'(k + 1);
            if (shoot_tag == TW'(k + 1)) begin
                shoot_ok = shoot_valid && ckpt_v[k];
                shoot_map = ckpt[k];
            end
            if (ckpt_sel[k]) ckpt_ok = ckpt_valid && !ckpt_v[k];
        end
        for (int k = 0; k < MAX_PREDICT_DEPTH; k++)
            kill[k] = shoot_ok && k + 1 >= int'(shoot_tag);
        // A shoot restores the checkpoint but must not lose commits retiring in the same cycle.
        nxt = shoot_ok ? shoot_map | fmask : (bitmap & ~gmask) | fmask;
    end

    always_ff @(posedge clk)
        if (reset) begin
            bitmap <= {{(NUM_PREGS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
            ckpt_v <= '0;
            state <= RUN;
            err <= 1'b0;
            for (int k = 0; k < MAX_PREDICT_DEPTH; k++)
                ckpt[k] <= '0;
        end else begin
            bitmap <= nxt;
            state <= shoot_ok ? RECOVER : RUN;
            err <= err | free_err | (ckpt_valid && !ckpt_ok) | (shoot_valid && !shoot_ok);
            for (int k = 0; k < MAX_PREDICT_DEPTH; k++) begin
                ckpt[k] <= ckpt_ok && ckpt_sel[k] ? nxt : ckpt[k] | fmask;
                ckpt_v[k] <= (ckpt_v[k] | (ckpt_ok && ckpt_sel[k])) & ~res_sel[k] & ~kill[k];
            end
        end
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb_rename_alloc_ctrl: directed and randomized checking of rename_alloc_ctrl against a
// free-set/checkpoint reference model; honours RENAME_DUAL_ALLOC_EN like the design.
module tb_rename_alloc_ctrl;
    localparam int NP = 64, NA = 32, D = 4, PW = 6, TW = 3;
`ifdef RENAME_DUAL_ALLOC_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    logic clk = 1'b0, reset;
    logic [1:0] alloc_req, free_valid;
    logic alloc_ready, ckpt_valid, shoot_valid, resolve_valid, recovering, err;
    logic [PW-1:0] alloc_preg0, alloc_preg1, free_preg0, free_preg1;
    logic [TW-1:0] ckpt_tag, shoot_tag, resolve_tag;
    logic [PW:0] num_free;

    rename_alloc_ctrl dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
        .alloc_preg0(alloc_preg0), .alloc_preg1(alloc_preg1), .free_valid(free_valid),
        .free_preg0(free_preg0), .free_preg1(free_preg1), .ckpt_valid(ckpt_valid),
        .ckpt_tag(ckpt_tag), .shoot_valid(shoot_valid), .shoot_tag(shoot_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .num_free(num_free),
        .recovering(recovering), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit live = 1'b0;
    bit [NP-1:0] m_free;
    bit [NP-1:0] m_cp [D];
    bit [D-1:0] m_cv;
    bit m_rec, m_err;
    int e_ready, e_p0, e_p1, e_nf, e_rec, e_err;

    function automatic int lowest(bit [NP-1:0] v, int skip);
        for (int i = 0; i < NP; i++)
            if (v[i] && i != skip) return i;
        return -1;
    endfunction

    task automatic expect_outputs();
        int n, f0, f1;
        bit [1:0] r;
        n = $countones(m_free);
        f0 = lowest(m_free, -1);
        f1 = f0 < 0 ? -1 : lowest(m_free, f0);
        r = DUAL ? alloc_req : {1'b0, alloc_req[0]};
        e_ready = (!m_rec && !shoot_valid && (DUAL ? n >= $countones(r) : n >= 1)) ? 1 : 0;
        e_p0 = f0 < 0 ? 0 : f0;
        e_p1 = !DUAL ? 0 : (r == 2'b10 ? e_p0 : (f1 < 0 ? 0 : f1));
        e_nf = n;
        e_rec = m_rec ? 1 : 0;
        e_err = m_err ? 1 : 0;
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic lit(string name, int got, int mdl, int want);
        chk(name, got, want);
        chk({name, "_model"}, mdl, want);
    endtask

    task automatic compare();
        expect_outputs();
        chk("alloc_ready", alloc_ready, e_ready);
        chk("alloc_preg0", alloc_preg0, e_p0);
        chk("alloc_preg1", alloc_preg1, e_p1);
        chk("num_free", num_free, e_nf);
        chk("recovering", recovering, e_rec);
        chk("err", err, e_err);
    endtask

    task automatic model_update();
        bit [NP-1:0] fr, nb;
        bit [D-1:0] cv;
        bit [1:0] r;
        bit sok;
        int t, ct, rt;
        if (reset) begin
            m_free = '0;
            for (int i = NA; i < NP; i++) m_free[i] = 1'b1;
            m_cv = '0;
            m_rec = 1'b0;
            m_err = 1'b0;
            return;
        end
        expect_outputs();
        r = DUAL ? alloc_req : {1'b0, alloc_req[0]};
        fr = '0;
        if (free_valid[0]) begin
            if (m_free[free_preg0]) m_err = 1'b1;
            fr[free_preg0] = 1'b1;
        end
        if (free_valid[1]) begin
            if (m_free[free_preg1] || fr[free_preg1]) m_err = 1'b1;
            fr[free_preg1] = 1'b1;
        end
        nb = m_free;
        if (e_ready == 1 && r != 2'b00) begin
            if (r[0]) nb[e_p0] = 1'b0;
            if (r[1]) nb[e_p1] = 1'b0;
        end
        nb |= fr;
        t = int'(shoot_tag);
        sok = 1'b0;
        if (shoot_valid && t >= 1 && t <= D) sok = m_cv[t-1];
        if (shoot_valid && !sok) m_err = 1'b1;
        if (sok) nb = m_cp[t-1] | fr;
        for (int k = 0; k < D; k++)
            if (m_cv[k]) m_cp[k] |= fr;
        cv = m_cv;
        ct = int'(ckpt_tag);
        if (ckpt_valid) begin
            if (ct >= 1 && ct <= D && !m_cv[(ct >= 1 ? ct - 1 : 0)]) begin
                m_cp[ct-1] = nb;
                cv[ct-1] = 1'b1;
            end else m_err = 1'b1;
        end
        rt = int'(resolve_tag);
        if (resolve_valid && rt >= 1 && rt <= D) cv[rt-1] = 1'b0;
        if (sok) for (int k = t - 1; k < D; k++) cv[k] = 1'b0;
        m_cv = cv;
        m_rec = sok;
        m_free = nb;
    endtask

    task automatic step();
        @(negedge clk);
        if (live) compare();
        @(posedge clk);
        model_update();
        live = 1'b1;
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; alloc_req = '0; free_valid = '0; free_preg0 = '0; free_preg1 = '0;
        ckpt_valid = 1'b0; ckpt_tag = '0; shoot_valid = 1'b0; shoot_tag = '0;
        resolve_valid = 1'b0; resolve_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic settle();
        #1;
        expect_outputs();
    endtask

    function automatic logic [PW-1:0] pick();
        int p;
        p = $urandom_range(0, NP - 1);
        if ($urandom_range(0, 39) == 0) return PW'(p);
        for (int j = 0; j < 8; j++) begin
            p = $urandom_range(0, NP - 1);
            if (!m_free[p]) return PW'(p);
        end
        return PW'(p);
    endfunction

    initial begin
        int k;
        do_reset();
        settle();
        lit("reset_num_free", num_free, e_nf, 32);
        lit("reset_preg0", alloc_preg0, e_p0, 32);
        lit("reset_recovering", recovering, e_rec, 0);
        lit("reset_err", err, e_err, 0);
        lit("reset_ready", alloc_ready, e_ready, 1);
        // two-slot request straight after reset
        alloc_req = 2'b11;
        settle();
        lit("dual_ready", alloc_ready, e_ready, 1);
        lit("dual_preg0", alloc_preg0, e_p0, 32);
        lit("dual_preg1", alloc_preg1, e_p1, DUAL ? 33 : 0);
        step();
        idle();
        settle();
        lit("dual_num_free", num_free, e_nf, DUAL ? 30 : 31);
        lit("dual_next_preg0", alloc_preg0, e_p0, DUAL ? 34 : 33);
        // double free
        do_reset();
        free_valid = 2'b01; free_preg0 = 6'd40;
        step();
        idle();
        settle();
        lit("dblfree_err", err, e_err, 1);
        lit("dblfree_num_free", num_free, e_nf, 32);
        // exhaustion
        do_reset();
        alloc_req = 2'b01;
        repeat (31) step();
        settle();
        lit("exh_num_free1", num_free, e_nf, 1);
        alloc_req = 2'b11;
        settle();
        lit("exh_ready11", alloc_ready, e_ready, DUAL ? 0 : 1);
        step();
        alloc_req = 2'b01;
        settle();
        lit("exh_after11", num_free, e_nf, DUAL ? 1 : 0);
        step();
        alloc_req = 2'b00;
        settle();
        lit("exh_num_free0", num_free, e_nf, 0);
        lit("exh_ready_idle", alloc_ready, e_ready, DUAL ? 1 : 0);
        // checkpoint, allocate, commit free, shoot
        do_reset();
        ckpt_valid = 1'b1; ckpt_tag = 3'd1;
        step();
        idle();
        alloc_req = 2'b01;
        repeat (4) step();
        idle();
        free_valid = 2'b01; free_preg0 = 6'd5;
        step();
        idle();
        settle();
        lit("shoot_pre_num_free", num_free, e_nf, 29);
        shoot_valid = 1'b1; shoot_tag = 3'd1; alloc_req = 2'b01;
        settle();
        lit("shoot_ready", alloc_ready, e_ready, 0);
        step();
        idle();
        alloc_req = 2'b01;
        settle();
        lit("shoot_num_free", num_free, e_nf, 33);
        lit("shoot_recovering", recovering, e_rec, 1);
        lit("recover_ready", alloc_ready, e_ready, 0);
        step();
        settle();
        lit("post_recover", recovering, e_rec, 0);
        lit("post_recover_ready", alloc_ready, e_ready, 1);
        // younger checkpoint dies with an older shoot
        do_reset();
        ckpt_valid = 1'b1; ckpt_tag = 3'd1;
        step();
        ckpt_tag = 3'd2;
        step();
        idle();
        alloc_req = 2'b01;
        step();
        idle();
        shoot_valid = 1'b1; shoot_tag = 3'd1;
        step();
        idle();
        step();
        settle();
        lit("kill_num_free", num_free, e_nf, 32);
        lit("kill_err0", err, e_err, 0);
        shoot_valid = 1'b1; shoot_tag = 3'd2;
        step();
        idle();
        settle();
        lit("kill_err1", err, e_err, 1);
        lit("kill_num_free_hold", num_free, e_nf, 32);
        lit("kill_no_recover", recovering, e_rec, 0);
        // resolve+shoot same tag, then reset mid-recover
        do_reset();
        ckpt_valid = 1'b1; ckpt_tag = 3'd1;
        step();
        idle();
        alloc_req = 2'b01;
        step();
        idle();
        shoot_valid = 1'b1; shoot_tag = 3'd1; resolve_valid = 1'b1; resolve_tag = 3'd1;
        step();
        idle();
        settle();
        lit("rs_recovering", recovering, e_rec, 1);
        lit("rs_num_free", num_free, e_nf, 32);
        lit("rs_err", err, e_err, 0);
        reset = 1'b1; shoot_valid = 1'b1; shoot_tag = 3'd1; alloc_req = 2'b01;
        free_valid = 2'b01; free_preg0 = 6'd5; ckpt_valid = 1'b1; ckpt_tag = 3'd2;
        step();
        idle();
        settle();
        lit("rst_rec_recovering", recovering, e_rec, 0);
        lit("rst_rec_num_free", num_free, e_nf, 32);
        lit("rst_rec_err", err, e_err, 0);
        // randomized traffic with periodic resets
        for (int c = 0; c < 3000; c++) begin
            idle();
            if (c % 250 == 0) reset = 1'b1;
            alloc_req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin free_valid[0] = 1'b1; free_preg0 = pick(); end
            if ($urandom_range(0, 2) == 0) begin free_valid[1] = 1'b1; free_preg1 = pick(); end
            if (free_valid == 2'b11 && free_preg0 == free_preg1 && $urandom_range(0, 9) != 0)
                free_valid[1] = 1'b0;
            k = $urandom_range(0, D - 1);
            ckpt_tag = TW'(k + 1);
            ckpt_valid = $urandom_range(0, 5) == 0 && (!m_cv[k] || $urandom_range(0, 19) == 0);
            k = $urandom_range(0, D - 1);
            shoot_tag = TW'(k + 1);
            shoot_valid = $urandom_range(0, 9) == 0 && (m_cv[k] || $urandom_range(0, 19) == 0);
            resolve_valid = $urandom_range(0, 7) == 0;
            resolve_tag = TW'($urandom_range(1, D));
            step();
        end
        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_alloc_ctrl.md
RENAME_ALLOC_CTRL -- requirements
Module: rename_alloc_ctrl

Interface
REQ-001 Parameters, one per line:
  - NUM_PREGS, default 64, number of physical registers.
  - NUM_ARCH, default 32, number of architecturally mapped registers at reset.
  - MAX_PREDICT_DEPTH, default 4, number of checkpoint tags; tag 0 means non-speculative.
REQ-002 Ports, one per line; PW = clog2(NUM_PREGS), TW = MAX_PREDICT_DEPTH_BITS:
  - clk  in  1  clock.
  - reset  in  1  synchronous, active-high reset.
  - alloc_req  in  2  per-slot destination-register request; bit1 is the younger slot.
  - alloc_ready  out  1  allocation accepted this cycle.
  - alloc_preg0, alloc_preg1  out  PW  granted pregs for slot 0 and slot 1.
  - free_valid  in  2  commit reclaim valids.
  - free_preg0, free_preg1  in  PW  pregs being reclaimed.
  - ckpt_valid  in  1  take a branch checkpoint.
  - ckpt_tag  in  TW  tag of the new checkpoint.
  - shoot_valid  in  1  mispredict recovery request.
  - shoot_tag  in  TW  tag to recover to.
  - resolve_valid  in  1  branch resolved correctly.
  - resolve_tag  in  TW  tag that resolved.
  - num_free  out  PW+1  population count of the free bitmap.
  - recovering  out  1  high while in RECOVER.
  - err  out  1  sticky protocol error.

Function
REQ-003 The block SHALL hold a free bitmap, MAX_PREDICT_DEPTH checkpoint bitmaps and a valid bit per checkpoint.
REQ-004 The block SHALL use a two-state FSM:
  - RUN to RECOVER on an accepted shoot_valid.
  - RECOVER to RUN unconditionally after one cycle.
REQ-005 alloc_ready SHALL equal state==RUN && !shoot_valid && num_free >= popcount(alloc_req), combinationally.
REQ-006 Allocation SHALL be all-or-nothing; a request is granted only when alloc_ready=1 and alloc_req!=0.
REQ-007 alloc_preg0 SHALL be the lowest-index free preg.
REQ-008 alloc_preg1 SHALL be the second-lowest free preg.
REQ-009 If only alloc_req[1] is set, slot 1 SHALL receive the lowest free preg, driven on alloc_preg1.
REQ-010 Granted pregs SHALL be cleared in the bitmap at the next clock edge.
REQ-011 Reclaimed pregs SHALL be set in the bitmap at the clock edge.
REQ-012 A preg freed in cycle N SHALL NOT be granted before cycle N+1.
REQ-013 Freeing an already-free preg SHALL set err and leave the bitmap unchanged for that preg.
REQ-014 ckpt_valid SHALL capture the bitmap after the same cycle's grants and frees into ckpt[ckpt_tag-1] and mark it valid.
REQ-015 Tag 0 or an already-valid tag on ckpt_valid SHALL set err and take no checkpoint.
REQ-016 Every commit free SHALL also be ORed into all valid checkpoints.
REQ-017 shoot_valid with valid tag t SHALL:
  - load the bitmap with ckpt[t-1] | same-cycle frees;
  - invalidate tags t..MAX_PREDICT_DEPTH;
  - enter RECOVER.
REQ-018 Same-cycle grants SHALL be suppressed during a shoot (alloc_ready=0).
REQ-019 shoot_valid with an invalid tag SHALL set err and be ignored.
REQ-020 shoot_valid while in RECOVER SHALL be accepted and restart RECOVER.
REQ-021 resolve_valid SHALL invalidate ckpt[resolve_tag-1] only.
REQ-022 Resolve and shoot of the same tag in one cycle SHALL resolve as a shoot.
REQ-023 recovering SHALL be 1 exactly in RECOVER, and alloc_ready SHALL be 0 there.
REQ-024 num_free SHALL reflect the registered bitmap, with no bypass.

Reset
REQ-025 On reset the block SHALL load:
  - bitmap = pregs NUM_ARCH..NUM_PREGS-1 free, 0..NUM_ARCH-1 allocated;
  - all checkpoints invalid;
  - state RUN, err 0.
REQ-026 After reset, num_free SHALL equal NUM_PREGS-NUM_ARCH (32) and alloc_preg0 SHALL equal NUM_ARCH.
REQ-027 Reset SHALL override any same-cycle shoot, free, checkpoint or allocation, including mid-RECOVER.

Configuration
REQ-028 With RENAME_DUAL_ALLOC_EN defined, both slots SHALL allocate per cycle.
REQ-029 Without RENAME_DUAL_ALLOC_EN:
  - alloc_req[1] is ignored;
  - alloc_preg1 is 0;
  - the alloc_ready threshold is 1;
  - the second-free search logic is absent.

Verification
REQ-030 Reset then alloc_req=2'b11 -> alloc_ready=1, pregs 32/33; next cycle num_free=30, alloc_preg0=34.
REQ-031 Allocate until num_free=1, then alloc_req=2'b11 -> alloc_ready=0, no change; alloc_req=2'b01 -> grant, num_free=0.
REQ-032 ckpt tag1 at num_free=32, allocate 4, free preg 5 -> shoot tag1 -> next cycle num_free=33, recovering=1 for one cycle, alloc_ready=0 then 1.
REQ-033 ckpt tags 1,2; shoot tag1 -> both invalid; later shoot tag2 -> err=1, bitmap unchanged.
REQ-034 Free preg 40 while free -> err=1, num_free unchanged.
REQ-035 Assert reset during RECOVER -> next cycle state RUN, num_free=32, recovering=0.
